// File: rtl/img2col_pkg.sv
// Shared types and width helpers for the img2col window buffer and its snapshot slot.
package img2col_pkg;

    // Beat interpretation selected by the mode input.
    typedef enum logic {
        MODE_ADDR  = 1'b0,
        MODE_SHIFT = 1'b1
    } mode_e;

    // Default element width and the matching element type.
    localparam int ELEM_W = 16;
    typedef logic [ELEM_W-1:0] elem_t;

    // clog2 that never collapses to zero, for counters whose range may be a single value.
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/img2col_snap_slot.sv
// One-entry hold register: loads a payload on demand and presents it with valid/ready.
module img2col_snap_slot #(
    parameter int PAYLOAD_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 load,
    input  logic [PAYLOAD_W-1:0] load_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic                 snap_ready
);

    logic                 valid_reg;
    logic [PAYLOAD_W-1:0] data_reg;

    // A load wins over a same-cycle consume, so back-to-back snapshots keep out_valid high.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid  = valid_reg;
    assign out_data   = data_reg;
    assign snap_ready = !valid_reg || out_ready;

endmodule

// File: rtl/img2col_window_buf.sv
// Multi-channel window register file: shift or addressed capture, per-entry valid
// tracking, and manual/automatic snapshots published through a one-entry slot.
module img2col_window_buf
    import img2col_pkg::*;
#(
    parameter int  DATA_W    = ELEM_W,
    parameter int  REG_NUM   = 5,
    parameter int  CH        = 1,
    parameter int  STRIDE    = 1,
    parameter int  AUTO_SNAP = 0,
    localparam int ADDR_W    = $clog2(REG_NUM),
    localparam int CNT_W     = $clog2(REG_NUM + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        mode,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CH*DATA_W-1:0]        in_data,
    input  logic [ADDR_W-1:0]           wr_addr,
    output logic                        addr_err,
    input  logic                        snap_req,
    output logic                        snap_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [REG_NUM*CH*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]            fill_count,
    output logic                        full
);

    localparam int SCNT_W = min1_clog2(STRIDE);
    localparam int PAY_W  = REG_NUM * CH * DATA_W;

    mode_e              mode_sel;
    logic [REG_NUM-1:0] vld_reg;
    logic [REG_NUM-1:0] vld_next;
    logic               armed_reg;
    logic [SCNT_W-1:0]  scnt_reg;
    logic               addr_err_reg;

    logic               beat_acc;
    logic               shift_acc;
    logic               addr_acc;
    logic               addr_oob;
    logic               shift_fills;
    logic               stride_hit;
    logic               auto_would;
    logic               auto_fire;
    logic               man_fire;
    logic               load;
    logic [PAY_W-1:0]   snap_next;

    assign mode_sel = mode_e'(mode);

    // A shift always sets the top entry, so the window is full after it iff entries 1.. are valid.
    assign shift_fills = &vld_reg[REG_NUM-1:1];
    assign stride_hit  = !armed_reg || (scnt_reg == SCNT_W'(STRIDE - 1));
    assign auto_would  = (AUTO_SNAP != 0) && (mode_sel == MODE_SHIFT) && shift_fills && stride_hit;

    // Stall only the beat that would emit a window while the slot cannot take it.
    assign in_ready  = !(auto_would && !snap_ready);
    assign beat_acc  = in_valid && in_ready;
    assign shift_acc = beat_acc && (mode_sel == MODE_SHIFT);
    assign addr_acc  = beat_acc && (mode_sel == MODE_ADDR);
    assign addr_oob  = (32'(wr_addr) >= REG_NUM);

    assign auto_fire = shift_acc && auto_would;
    assign man_fire  = snap_req && snap_ready;
    assign load      = (auto_fire || man_fire) && !clear;

    // Next-state valid bits, mirroring the data path's shift or addressed write.
    always_comb begin
        vld_next = vld_reg;
        if (shift_acc) begin
            vld_next = {1'b1, vld_reg[REG_NUM-1:1]};
        end else if (addr_acc) begin
            for (int i = 0; i < REG_NUM; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    vld_next[i] = 1'b1;
                end
            end
        end
    end

    // Control state: valid bits, auto-snapshot arming and stride counting, error pulse.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            vld_reg      <= '0;
            armed_reg    <= 1'b0;
            scnt_reg     <= '0;
            addr_err_reg <= 1'b0;
        end else begin
            vld_reg      <= vld_next;
            addr_err_reg <= addr_acc && addr_oob;
            if (auto_fire) begin
                armed_reg <= 1'b1;
                scnt_reg  <= '0;
            end else if (shift_acc && armed_reg) begin
                scnt_reg <= (scnt_reg == SCNT_W'(STRIDE - 1)) ? '0 : scnt_reg + SCNT_W'(1);
            end
        end
    end

    // Per-channel data path; every lane follows the shared control decisions.
    genvar gi, gj;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_lane
            logic [DATA_W-1:0] lane_reg  [REG_NUM];
            logic [DATA_W-1:0] lane_next [REG_NUM];
            logic [DATA_W-1:0] lane_in;

            assign lane_in = in_data[gi*DATA_W +: DATA_W];

            // Next-state lane contents, also used as the snapshot payload.
            always_comb begin
                lane_next = lane_reg;
                if (shift_acc) begin
                    for (int i = 0; i < REG_NUM - 1; i++) begin
                        lane_next[i] = lane_reg[i+1];
                    end
                    lane_next[REG_NUM-1] = lane_in;
                end else if (addr_acc) begin
                    for (int i = 0; i < REG_NUM; i++) begin
                        if (wr_addr == ADDR_W'(i)) begin
                            lane_next[i] = lane_in;
                        end
                    end
                end
            end

            // Lane storage; flushed by reset or clear.
            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    for (int i = 0; i < REG_NUM; i++) begin
                        lane_reg[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < REG_NUM; i++) begin
                        lane_reg[i] <= lane_next[i];
                    end
                end
            end

            for (gj = 0; gj < REG_NUM; gj++) begin : g_ent
                assign snap_next[(gj*CH+gi)*DATA_W +: DATA_W] = lane_next[gj];
            end
        end
    endgenerate

    img2col_snap_slot #(
        .PAYLOAD_W(PAY_W)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .load      (load),
        .load_data (snap_next),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .snap_ready(snap_ready)
    );

    // Occupancy is the number of set valid bits.
    always_comb begin
        fill_count = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            fill_count = fill_count + CNT_W'(vld_reg[i]);
        end
    end

    assign full     = &vld_reg;
    assign addr_err = addr_err_reg;

endmodule

// File: doc/img2col_window_buf.md
# img2col_window_buf

Parametrised, multi-channel window register file for the img2col stage. It captures pixels either by streaming shift or by addressed write, and tracks which entries hold valid data. It publishes complete windows through a one-entry snapshot slot with a valid/ready handshake. Snapshots are taken on demand, or automatically every STRIDE shifts, with back-pressure so no window is lost. It sits between the input pixel fetcher and the img2col column assembler.

## Interface
- DATA_W, 16, bits per element per channel
- REG_NUM, 5, window depth (entries); ≥2
- CH, 1, parallel channels sharing one control path
- STRIDE, 1, accepted shifts between automatic snapshots; ≥1
- AUTO_SNAP, 0, 1 = automatic snapshot in shift mode
- ADDR_W (localparam), $clog2(REG_NUM)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- clear  in  1  synchronous flush of window state
- mode  in  1  0 = addressed write, 1 = shift
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  CH*DATA_W  one element per channel; channel c at [c*DATA_W +: DATA_W]
- wr_addr  in  ADDR_W  entry index for addressed write
- addr_err  out  1  one-cycle pulse: accepted addressed write with wr_addr ≥ REG_NUM
- snap_req  in  1  manual snapshot request
- snap_ready  out  1  = !out_valid || out_ready
- out_valid  out  1  snapshot slot holds a window
- out_ready  in  1  consumer takes the snapshot
- out_data  out  REG_NUM*CH*DATA_W  entry i, channel c at [(i*CH+c)*DATA_W +: DATA_W]
- fill_count  out  $clog2(REG_NUM+1)  number of valid entries
- full  out  1  fill_count == REG_NUM

## Operation
- State:
  - array reg[REG_NUM][CH]
  - per-entry valid bits vld[REG_NUM]
  - stride counter scnt (0..STRIDE-1)
  - armed flag (first auto-window already emitted)
  - snapshot slot
- Shift beat (mode=1, accepted):
  - reg[i] <= reg[i+1] for i < REG_NUM-1; reg[REG_NUM-1] <= in_data; reg[0] content discarded
  - vld shifts identically; vld[REG_NUM-1] <= 1
- Addressed beat (mode=0, accepted):
  - wr_addr < REG_NUM: reg[wr_addr] <= in_data; vld[wr_addr] <= 1
  - otherwise: data dropped, addr_err pulses next cycle, no state change
- fill_count = popcount(vld); full = &vld.
- Auto trigger (AUTO_SNAP=1, shift beat accepted, next-state full):
  - fires when armed=0 (first full window), then sets armed=1
  - fires when armed=1 and scnt==STRIDE-1
  - scnt resets to 0 on each firing; otherwise increments on each accepted shift while armed
- Manual trigger: snap_req && snap_ready.
- Either trigger loads the slot with the next-state array, including this cycle's write. Simultaneous manual and auto triggers produce one snapshot.
- Slot: out_valid clears on out_valid && out_ready unless a new trigger loads it in the same cycle.
- in_ready = 0 only when AUTO_SNAP=1, mode=1, the beat would fire an auto trigger, and snap_ready=0. Otherwise in_ready = 1.
- A manual snap_req while snap_ready=0 is ignored; the requester must hold it.
- clear zeroes reg, vld, scnt, armed and out_valid. It has priority over any same-cycle beat or trigger; in_ready stays as computed, but the beat is discarded.
- Mode change between beats is allowed. Addressed writes do not advance scnt.

## Timing
- Reset values: in_ready=1, addr_err=0, snap_ready=1, out_valid=0, out_data=0, fill_count=0, full=0; all internal state 0.
- rst mid-operation: state is identical to post-reset on the next cycle; any pending snapshot is lost.
- Write latency: 1 cycle (fill_count/full update the cycle after acceptance).
- Snapshot latency: out_valid high the cycle after the trigger edge; out_data stable while out_valid && !out_ready.
- Back-to-back snapshots: a trigger in the same cycle as out_ready reloads the slot, so out_valid stays high.
- in_ready and snap_ready are combinational from out_valid/out_ready/mode/in_valid/state; there is no combinational path from in_data.

## Structure
- Package img2col_pkg:
  - typedef enum logic {MODE_ADDR, MODE_SHIFT}
  - element typedef logic [DATA_W-1:0] helper
  - shared clog2-based width constants
- Sub-module img2col_snap_slot: one-entry hold register with load/valid/ready, parametrised on payload width.
- Top holds array, valid bits, counters and trigger logic; channels are a generate loop over the data path only.

## Test plan
- Reset, then 5 shift beats 1..5 (REG_NUM=5, CH=1), snap_req → out_data entries 0..4 = 1,2,3,4,5; fill_count 5; full=1.
- Addressed writes addr 2=0xAA, addr 7 → fill_count 1, entry 2=0xAA, addr_err pulses once for addr 7.
- AUTO_SNAP=1, STRIDE=2, stream 1..9 with out_ready=1 → windows {1..5}, {3..7}, {5..9}.
- Same config, out_ready=0 after the first window → in_ready drops on beat 7; stream resumes with no loss once out_ready=1.
- clear asserted in the same cycle as a shift and a snap_req → next cycle fill_count=0, out_valid=0, array all zero.
- CH=3: per-channel data lands in the correct lanes; rst mid-stream restores all reset values.
